// File: rtl/data_ram.sv
// data_ram: byte-addressed data memory with sub-word access, registered reads, fault reporting
module data_ram #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [1:0]            a_size_i,
  input  logic                  a_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  output logic                  a_rvalid_o,
  output logic                  a_err_o,
  input  logic                  b_req_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  b_rvalid_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IDX   = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX-1:0]        a_idx, b_idx;
  logic [OFS-1:0]        a_ofs;
  logic [3:0]            nbytes;
  logic [6:0]            nbits, sa;
  logic [8:0]            bmask;
  logic [BYTES-1:0]      be;
  logic                  fault;
  logic [DATA_WIDTH-1:0] wsh, rsh, ld;
  logic [DATA_WIDTH-1:0] a_rdata_d, a_rdata_q, b_rdata_d, b_rdata_q;
  logic                  a_rvalid_d, a_rvalid_q, a_err_d, a_err_q, b_rvalid_d, b_rvalid_q;
  assign a_idx = a_addr_i[OFS+IDX-1:OFS];
  assign a_ofs = a_addr_i[OFS-1:0];
  assign b_idx = b_addr_i[OFS+IDX-1:OFS];
  always_comb begin
    nbytes = 4'd1 << a_size_i;
    nbits  = 7'd8 << a_size_i;
    sa     = 7'(DATA_WIDTH) - nbits;
    bmask  = (9'd1 << nbytes) - 9'd1;
    be     = BYTES'(bmask << a_ofs);
    fault  = |(a_ofs & OFS'(nbytes - 4'd1))
           | ((a_size_i == 2'b11) && (DATA_WIDTH == 32))
           | ((a_addr_i >> (OFS + IDX)) != '0);
    wsh    = a_wdata_i << {a_ofs, 3'b000};
    rsh    = mem[a_idx] >> {a_ofs, 3'b000};
    // left-justify the sub-word, then shift back to extend it
    ld     = a_unsigned_i ? (rsh << sa) >> sa : DATA_WIDTH'($signed(rsh << sa) >>> sa);
    a_err_d    = a_req_i & fault;
    a_rvalid_d = a_req_i & ~a_we_i & ~fault;
    a_rdata_d  = a_err_d ? '0 : a_rvalid_d ? ld : a_rdata_q;
    b_rvalid_d = b_req_i;
    b_rdata_d  = b_req_i ? mem[b_idx] : b_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_rdata_q  <= '0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rdata_q  <= a_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      a_err_q    <= a_err_d;
      b_rdata_q  <= b_rdata_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && a_req_i && a_we_i && !fault)
      for (int i = 0; i < BYTES; i++)
        if (be[i]) mem[a_idx][i*8 +: 8] <= wsh[i*8 +: 8];
  end
  assign a_rdata_o  = a_rdata_q;
  assign a_rvalid_o = a_rvalid_q;
  assign a_err_o    = a_err_q;
  assign b_rdata_o  = b_rdata_q;
  assign b_rvalid_o = b_rvalid_q;
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed vectors for data_ram with hand-computed expectations
module tb_data_ram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, a_unsigned = 1'b0, b_req = 1'b0;
  logic [1:0]  a_size = 2'd0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0;
  logic [31:0] a_rdata, b_rdata;
  logic        a_rvalid, a_err, b_rvalid;
  int          total = 0, bad = 0;
  data_ram dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_size_i(a_size), .a_unsigned_i(a_unsigned),
    .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rdata_o(a_rdata), .a_rvalid_o(a_rvalid),
    .a_err_o(a_err), .b_req_i(b_req), .b_addr_i(b_addr), .b_rdata_o(b_rdata),
    .b_rvalid_o(b_rvalid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    a_req = 1'b0;
    a_we  = 1'b0;
    b_req = 1'b0;
  endtask
  task automatic a_op(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    a_req = 1'b1; a_we = we; a_size = sz; a_unsigned = uns; a_addr = addr; a_wdata = wd;
    step();
  endtask
  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
    a_op(1'b0, sz, uns, addr, '0);
    check({tag, "_v"}, {31'b0, a_rvalid}, 32'd1);
    check({tag, "_e"}, {31'b0, a_err}, 32'd0);
    check(tag, a_rdata, exp);
  endtask
  task automatic fault_chk(input string tag, input logic we, input logic [1:0] sz,
                           input logic [31:0] addr);
    a_op(we, sz, 1'b0, addr, 32'h5555_5555);
    check({tag, "_e"}, {31'b0, a_err}, 32'd1);
    check({tag, "_v"}, {31'b0, a_rvalid}, 32'd0);
    check({tag, "_d"}, a_rdata, 32'd0);
  endtask
  initial begin
    step();
    step();
    check("rst_ard", a_rdata, 0);
    check("rst_av", {31'b0, a_rvalid}, 0);
    check("rst_ae", {31'b0, a_err}, 0);
    check("rst_brd", b_rdata, 0);
    check("rst_bv", {31'b0, b_rvalid}, 0);
    rst = 1'b0;
    a_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("st_v", {31'b0, a_rvalid}, 0);
    check("st_e", {31'b0, a_err}, 0);
    load_chk("word_rt", 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    step();
    check("hold_v", {31'b0, a_rvalid}, 0);
    check("hold_d", a_rdata, 32'hDEAD_BEEF);
    a_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
    a_op(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FFAA);
    a_op(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF_1234);
    load_chk("subword", 2'd2, 1'b0, 32'h20, 32'h1234_AA00);
    a_op(1'b1, 2'd2, 1'b0, 32'h30, 32'h0000_F080);
    load_chk("lb_s", 2'd0, 1'b0, 32'h30, 32'hFFFF_FF80);
    load_chk("lb_u", 2'd0, 1'b1, 32'h30, 32'h0000_0080);
    load_chk("lh_s", 2'd1, 1'b0, 32'h30, 32'hFFFF_F080);
    load_chk("lh_u", 2'd1, 1'b1, 32'h30, 32'h0000_F080);
    load_chk("lb_s1", 2'd0, 1'b0, 32'h31, 32'hFFFF_FFF0);
    load_chk("lb_u2", 2'd0, 1'b1, 32'h22, 32'h0000_0034);
    load_chk("lh_s2", 2'd1, 1'b0, 32'h22, 32'h0000_1234);
    load_chk("lw_uns", 2'd2, 1'b1, 32'h10, 32'hDEAD_BEEF);
    fault_chk("f_mis_st", 1'b1, 2'd2, 32'h13);
    load_chk("f_unchg", 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    fault_chk("f_oor", 1'b0, 2'd2, 32'h400);
    fault_chk("f_size", 1'b0, 2'd3, 32'h10);
    fault_chk("f_mis_lh", 1'b0, 2'd1, 32'h11);
    fault_chk("f_oor_st", 1'b1, 2'd0, 32'h8000_0010);
    load_chk("f_unchg2", 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    a_op(1'b1, 2'd2, 1'b0, 32'h40, 32'h2222_2222);
    b_req = 1'b1; b_addr = 32'h40;
    a_op(1'b1, 2'd2, 1'b0, 32'h40, 32'h1111_1111);
    check("rbw_v", {31'b0, b_rvalid}, 1);
    check("rbw_d", b_rdata, 32'h2222_2222);
    b_req = 1'b1; b_addr = 32'h42;
    step();
    check("b_new", b_rdata, 32'h1111_1111);
    b_req = 1'b1; b_addr = 32'h440;
    step();
    check("b_wrap", b_rdata, 32'h1111_1111);
    check("b_wrap_v", {31'b0, b_rvalid}, 1);
    b_req = 1'b1; b_addr = 32'h10;
    step();
    check("b_w10", b_rdata, 32'hDEAD_BEEF);
    step();
    check("b_idle_v", {31'b0, b_rvalid}, 0);
    check("b_idle_d", b_rdata, 32'hDEAD_BEEF);
    a_op(1'b1, 2'd2, 1'b0, 32'h50, 32'h1234_5678);
    load_chk("pre_rst", 2'd2, 1'b0, 32'h20, 32'h1234_AA00);
    rst = 1'b1; b_req = 1'b1; b_addr = 32'h10;
    a_op(1'b1, 2'd2, 1'b0, 32'h50, 32'hFFFF_FFFF);
    rst = 1'b0;
    check("mr_ard", a_rdata, 0);
    check("mr_av", {31'b0, a_rvalid}, 0);
    check("mr_ae", {31'b0, a_err}, 0);
    check("mr_brd", b_rdata, 0);
    check("mr_bv", {31'b0, b_rvalid}, 0);
    load_chk("mr_keep", 2'd2, 1'b0, 32'h50, 32'h1234_5678);
    load_chk("mr_resume", 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
